matrix_keypad_scanner: RTL and testbench
========================================

// Module: matrix_keypad_scanner
// PURPOSE
//  Parametrised ROWS x COLS keypad scanner for the organ front panel; replaces the fixed 4x4 driver.
//  Debounces press and release, emits one-cycle press/release events with a linear key code,
//  and exposes a held level for note sustain. Sits between the keypad pins and the tone selector.
// PARAMETERS
//  ROWS            4          number of row inputs (2..8)
//  COLS            4          number of column drive outputs (2..8)
//  DEBOUNCE_CYCLES 1_000_000  consecutive stable cycles to accept press or release (20 ms @ 50 MHz)
//  SETTLE_CYCLES   2          cycles between column change and row sample
//  REPEAT_DELAY    25_000_000 first auto-repeat after this many held cycles (KEY_REPEAT_EN only)
//  REPEAT_PERIOD   5_000_000  auto-repeat interval (KEY_REPEAT_EN only)
//  KEY_W           $clog2(ROWS*COLS)  key code width (derived localparam)
// PORTS
//  clk        in   1      system clock; single clock domain
//  rst        in   1      asynchronous, active-high reset
//  row_data   in   ROWS   keypad rows, pulled up, low = contact; asynchronous to clk
//  col_data   out  COLS   column drive, low = driven
//  key_valid  out  1      one-cycle event strobe
//  key_press  out  1      qualifies key_valid: 1 = press/repeat, 0 = release
//  key_code   out  KEY_W  row*COLS + col, row i = row_data[i], col j = col_data[j]
//  key_held   out  1      high from press event until release event
// BEHAVIOUR
//  - row_data passes a 2-flop synchroniser; all decisions use the synchronised value (rs).
//  - Reset: col_data = 0 (all columns driven), key_valid = 0, key_press = 0, key_code = 0,
//    key_held = 0, FSM = IDLE, all counters 0. Reset mid-scan/mid-hold aborts without any event.
//  - IDLE: col_data = 0. rs != all-ones -> DEB_P.
//  - DEB_P: count while rs != all-ones; rs == all-ones -> IDLE, count cleared;
//    count reaches DEBOUNCE_CYCLES -> SCAN with col index 0.
//  - SCAN: drive only current column low; wait SETTLE_CYCLES, then sample rs.
//    Any row low -> capture lowest-index low row and current col, go REPORT.
//    None low: next column; after column COLS-1 -> IDLE (no event).
//  - REPORT: key_valid = 1, key_press = 1, key_code = captured; key_held set; -> HELD. One cycle.
//  - HELD: only captured column driven; watch captured row bit only. Other keys ignored.
//    Captured bit high -> DEB_R.
//  - DEB_R: count while captured bit high; bit low again -> HELD, no event, count cleared.
//    Count reaches DEBOUNCE_CYCLES -> key_valid = 1, key_press = 0, same key_code,
//    key_held cleared in the same cycle -> IDLE.
//  - key_code holds its value between events; changes only on a press event.
//  - Press-to-event latency: 2 (sync) + DEBOUNCE_CYCLES + scan time
//    (col+1)*(SETTLE_CYCLES+1) + 1 cycles; release latency: 2 + DEBOUNCE_CYCLES + 1.
//  - Counters sized by $clog2 of their limit; no wrap: they saturate/clear as above.
//  - key_valid never high on two consecutive cycles; release event always follows its press.
// CONFIGURATION
//  KEY_REPEAT_EN defined: in HELD, count held cycles; at REPEAT_DELAY emit key_valid = 1,
//    key_press = 1, same key_code, then every REPEAT_PERIOD. Repeat counter clears on
//    entering HELD from REPORT; DEB_R pauses it; return to HELD from DEB_R resumes it.
//  KEY_REPEAT_EN undefined: no repeat logic; exactly one press event per physical press.
//    REPEAT_* parameters unused.
// TESTING  (bench uses DEBOUNCE_CYCLES=16, SETTLE_CYCLES=2, REPEAT_DELAY=64, REPEAT_PERIOD=32)
//  1 Press row1/col2 (4x4), hold 200 cycles, release -> one press event key_code=6,
//    key_held high until one release event key_code=6; col_data returns to 0.
//  2 Bounce: row toggles every 5 cycles for 60 cycles then releases -> no key_valid ever.
//  3 Release bounce: press key 0, drop contact 8 cycles mid-hold -> no release event;
//    final stable release -> exactly one release event.
//  4 Two keys row2/col0 and row3/col3 pressed together -> press code 8 only;
//    release of key 15 alone -> no event; release of key 8 -> release code 8.
//  5 ROWS=2, COLS=8: press row1/col7 -> key_code=15; assert rst during HELD ->
//    all outputs zero next cycle, no release event.
//  6 KEY_REPEAT_EN: hold key 5 for 200 cycles -> press, repeats at +64, +96, +128, +160,
//    +192 cycles after press event, then release; without macro only press and release.

Source files
------------

// File: rtl/matrix_keypad_scanner.sv
// ============================================================================
// Module      : matrix_keypad_scanner
// Description : Debounced ROWS x COLS keypad scanner with press/release events,
//               linear key code and held level. Define KEY_REPEAT_EN to add
//               auto-repeat press events while a key stays held.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_keypad_scanner #(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SETTLE_CYCLES   = 2,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_PERIOD   = 5_000_000,
  localparam int KEY_W          = $clog2(ROWS * COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [ROWS-1:0]  row_data,
  output logic [COLS-1:0]  col_data,
  output logic             key_valid,
  output logic             key_press,
  output logic [KEY_W-1:0] key_code,
  output logic             key_held
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 2);

  localparam logic [DW-1:0] C_DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] C_SETTLE     = SW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] C_COL_LAST   = CW'(COLS - 1);

  if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || DEBOUNCE_CYCLES < 2 ||
      REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_param_error
    $error("matrix_keypad_scanner: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEB_P  = 3'd1,
    S_SCAN   = 3'd2,
    S_REPORT = 3'd3,
    S_HELD   = 3'd4,
    S_DEB_R  = 3'd5
  } state_t;

  state_t           r_state;
  logic [ROWS-1:0]  r_row_meta;
  logic [ROWS-1:0]  r_rs;
  logic [DW-1:0]    r_deb_cnt;
  logic [SW-1:0]    r_settle_cnt;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;

  logic             w_any_low;
  logic             w_cap_high;
  logic [RW-1:0]    w_low_row;
  logic [KEY_W-1:0] w_code;

  // Idle level of the synchroniser is all-ones so reset does not look like a press
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row_meta <= '1;
      r_rs       <= '1;
    end else begin
      r_row_meta <= row_data;
      r_rs       <= r_row_meta;
    end
  end

  assign w_any_low  = (r_rs != '1);
  assign w_cap_high = r_rs[r_row];
  assign w_code     = KEY_W'(int'(r_row) * COLS + int'(r_col));

  always_comb begin
    w_low_row = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!r_rs[i]) w_low_row = RW'(i);
    end
  end

`ifdef KEY_REPEAT_EN
  localparam int RPW = $clog2(((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD) + 1);

  logic [RPW-1:0] r_rep_cnt;
  logic           r_rep_armed;
  logic           w_rep_fire;

  assign w_rep_fire = (r_rep_cnt == (r_rep_armed ? RPW'(REPEAT_PERIOD - 1) : RPW'(REPEAT_DELAY - 1)));
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      col_data     <= '0;
      key_valid    <= 1'b0;
      key_press    <= 1'b0;
      key_code     <= '0;
      key_held     <= 1'b0;
      r_deb_cnt    <= '0;
      r_settle_cnt <= '0;
      r_col        <= '0;
      r_row        <= '0;
`ifdef KEY_REPEAT_EN
      r_rep_cnt    <= '0;
      r_rep_armed  <= 1'b0;
`endif
    end else begin
      key_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          col_data <= '0;
          // The sample that leaves IDLE already counts as the first stable cycle
          if (w_any_low) begin
            r_deb_cnt <= DW'(1);
            r_state   <= S_DEB_P;
          end
        end
        S_DEB_P: begin
          if (!w_any_low) begin
            r_deb_cnt <= '0;
            r_state   <= S_IDLE;
          end else if (r_deb_cnt == C_DEB_LAST) begin
            r_deb_cnt    <= '0;
            r_col        <= '0;
            r_settle_cnt <= '0;
            col_data     <= ~COLS'(1);
            r_state      <= S_SCAN;
          end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
          end
        end
        S_SCAN: begin
          if (r_settle_cnt != C_SETTLE) begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
          end else if (w_any_low) begin
            r_row   <= w_low_row;
            r_state <= S_REPORT;
          end else if (r_col == C_COL_LAST) begin
            col_data <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_col        <= r_col + CW'(1);
            r_settle_cnt <= '0;
            col_data     <= ~(COLS'(1) << (r_col + CW'(1)));
          end
        end
        S_REPORT: begin
          key_valid <= 1'b1;
          key_press <= 1'b1;
          key_code  <= w_code;
          key_held  <= 1'b1;
          r_state   <= S_HELD;
`ifdef KEY_REPEAT_EN
          r_rep_cnt   <= '0;
          r_rep_armed <= 1'b0;
`endif
        end
        S_HELD: begin
          if (w_cap_high) begin
            r_deb_cnt <= '0;
            r_state   <= S_DEB_R;
          end
`ifdef KEY_REPEAT_EN
          else if (w_rep_fire) begin
            key_valid   <= 1'b1;
            key_press   <= 1'b1;
            r_rep_cnt   <= '0;
            r_rep_armed <= 1'b1;
          end else begin
            r_rep_cnt <= r_rep_cnt + RPW'(1);
          end
`endif
        end
        S_DEB_R: begin
          if (!w_cap_high) begin
            r_deb_cnt <= '0;
            r_state   <= S_HELD;
          end else if (r_deb_cnt == C_DEB_LAST) begin
            key_valid <= 1'b1;
            key_press <= 1'b0;
            key_held  <= 1'b0;
            col_data  <= '0;
            r_deb_cnt <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_deb_cnt <= r_deb_cnt + DW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_keypad_scanner.sv
// ============================================================================
// Module      : tb_matrix_keypad_scanner
// Description : Directed scoreboard bench for matrix_keypad_scanner (4x4 and 2x8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_matrix_keypad_scanner;

  localparam int DEB = 16;
  localparam int SET = 2;
  localparam int RD  = 64;
  localparam int RP  = 32;

  typedef struct {
    bit press;
    int code;
    int cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rst_b;
  logic [3:0] row_data_a;
  logic [3:0] col_data_a;
  logic       key_valid_a, key_press_a, key_held_a;
  logic [3:0] key_code_a;
  logic [1:0] row_data_b;
  logic [7:0] col_data_b;
  logic       key_valid_b, key_press_b, key_held_b;
  logic [3:0] key_code_b;

  bit   key_a [4][4];
  bit   key_b [2][8];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   ev_a = 0;
  int   ev_b = 0;
  ev_t  q_a[$];
  ev_t  q_b[$];
  logic kvp_a = 1'b0;
  logic kvp_b = 1'b0;

  matrix_keypad_scanner #(
    .ROWS(4), .COLS(4), .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_a (
    .clk(clk), .rst(rst), .row_data(row_data_a), .col_data(col_data_a),
    .key_valid(key_valid_a), .key_press(key_press_a), .key_code(key_code_a),
    .key_held(key_held_a)
  );

  matrix_keypad_scanner #(
    .ROWS(2), .COLS(8), .DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut_b (
    .clk(clk), .rst(rst_b), .row_data(row_data_b), .col_data(col_data_b),
    .key_valid(key_valid_b), .key_press(key_press_b), .key_code(key_code_b),
    .key_held(key_held_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Passive keypad: a row is pulled low when a closed key sits on a driven column
  always_comb begin
    row_data_a = '1;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (key_a[r][c] && !col_data_a[c]) row_data_a[r] = 1'b0;
    row_data_b = '1;
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 8; c++)
        if (key_b[r][c] && !col_data_b[c]) row_data_b[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void exp_a(input bit p, input int code, input int c);
    ev_t e;
    e.press = p; e.code = code; e.cyc = c;
    q_a.push_back(e);
  endfunction

  function automatic void exp_b(input bit p, input int code, input int c);
    ev_t e;
    e.press = p; e.code = code; e.cyc = c;
    q_b.push_back(e);
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (key_valid_a) begin
      ev_a++;
      check("a_valid_gap", kvp_a, 0);
      check("a_event_queued", q_a.size() != 0, 1);
      if (q_a.size() != 0) begin
        e = q_a.pop_front();
        check("a_press", key_press_a, e.press);
        check("a_code", key_code_a, e.code);
        if (e.cyc >= 0) check("a_cycle", cyc, e.cyc);
      end
    end
    kvp_a = key_valid_a;
  end

  always @(negedge clk) begin
    ev_t e;
    if (key_valid_b) begin
      ev_b++;
      check("b_valid_gap", kvp_b, 0);
      check("b_event_queued", q_b.size() != 0, 1);
      if (q_b.size() != 0) begin
        e = q_b.pop_front();
        check("b_press", key_press_b, e.press);
        check("b_code", key_code_b, e.code);
        if (e.cyc >= 0) check("b_cycle", cyc, e.cyc);
      end
    end
    kvp_b = key_valid_b;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drain_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_a.size() == 0) break;
      tick(1);
    end
    check("a_drain", q_a.size(), 0);
  endtask

  task automatic drain_b(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q_b.size() == 0) break;
      tick(1);
    end
    check("b_drain", q_b.size(), 0);
  endtask

  // Press, hold 200 cycles past the press event, release; checks exact latencies
  task automatic held_key_test(input int r, input int c);
    int t0, p, lat, code;
    logic [3:0] exp_col;
    code    = r * 4 + c;
    lat     = 2 + DEB + (c + 1) * (SET + 1) + 1;
    exp_col = ~(4'b0001 << c);
    t0 = cyc;
    p  = t0 + lat;
    exp_a(1'b1, code, p);
    key_a[r][c] = 1'b1;
    drain_a(lat + 10);
    check("a_held_after_press", key_held_a, 1);
    check("a_col_while_held", col_data_a, exp_col);
`ifdef KEY_REPEAT_EN
    exp_a(1'b1, code, p + RD);
    for (int k = 1; k <= 4; k++) exp_a(1'b1, code, p + RD + k * RP);
`endif
    tick(200);
    check("a_held_during_hold", key_held_a, 1);
    drain_a(1);
    t0 = cyc;
    exp_a(1'b0, code, t0 + 2 + DEB + 1);
    key_a[r][c] = 1'b0;
    drain_a(60);
    check("a_held_after_release", key_held_a, 0);
    tick(2);
    check("a_col_after_release", col_data_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n0;
    rst   = 1'b1;
    rst_b = 1'b1;
    tick(3);
    check("rst_col", col_data_a, 0);
    check("rst_valid", key_valid_a, 0);
    check("rst_press", key_press_a, 0);
    check("rst_code", key_code_a, 0);
    check("rst_held", key_held_a, 0);
    check("rst_col_b", col_data_b, 0);
    rst   = 1'b0;
    rst_b = 1'b0;
    tick(5);

    // Key 6: row 1, column 2
    held_key_test(1, 2);
    tick(10);

    // Contact chatter shorter than the debounce window
    n0 = ev_a;
    for (int i = 0; i < 12; i++) begin
      key_a[0][0] = ~key_a[0][0];
      tick(5);
    end
    key_a[0][0] = 1'b0;
    tick(60);
    check("bounce_no_event", ev_a, n0);
    check("bounce_not_held", key_held_a, 0);

    // Brief contact loss while holding key 0
    t0 = cyc;
    exp_a(1'b1, 0, t0 + 2 + DEB + 3 + 1);
    key_a[0][0] = 1'b1;
    drain_a(40);
    tick(20);
    n0 = ev_a;
    key_a[0][0] = 1'b0;
    tick(8);
    key_a[0][0] = 1'b1;
    tick(20);
    check("dropout_no_event", ev_a, n0);
    check("dropout_still_held", key_held_a, 1);
    t0 = cyc;
    exp_a(1'b0, 0, t0 + 2 + DEB + 1);
    key_a[0][0] = 1'b0;
    drain_a(40);
    check("dropout_released", key_held_a, 0);
    tick(10);

    // Keys 8 and 15 together: lowest column scanned first wins
    t0 = cyc;
    exp_a(1'b1, 8, t0 + 2 + DEB + 3 + 1);
    key_a[2][0] = 1'b1;
    key_a[3][3] = 1'b1;
    drain_a(40);
    tick(20);
    n0 = ev_a;
    key_a[3][3] = 1'b0;
    tick(30);
    check("other_key_ignored", ev_a, n0);
    check("other_key_held", key_held_a, 1);
    t0 = cyc;
    exp_a(1'b0, 8, t0 + 2 + DEB + 1);
    key_a[2][0] = 1'b0;
    drain_a(40);
    tick(10);

    // 2x8 instance: key 15, then reset while held
    t0 = cyc;
    exp_b(1'b1, 15, t0 + 2 + DEB + 8 * (SET + 1) + 1);
    key_b[1][7] = 1'b1;
    drain_b(80);
    check("b_held", key_held_b, 1);
    check("b_col_while_held", col_data_b, 8'h7F);
    n0 = ev_b;
    rst_b = 1'b1;
    @(negedge clk);
    check("b_rst_col", col_data_b, 0);
    check("b_rst_valid", key_valid_b, 0);
    check("b_rst_press", key_press_b, 0);
    check("b_rst_code", key_code_b, 0);
    check("b_rst_held", key_held_b, 0);
    key_b[1][7] = 1'b0;
    tick(3);
    rst_b = 1'b0;
    tick(40);
    check("b_no_release_after_rst", ev_b, n0);
    check("b_queue_empty", q_b.size(), 0);

    // Key 5: row 1, column 1
    held_key_test(1, 1);
    tick(10);
    check("a_queue_empty", q_a.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
